// File: rtl/cell_proc_if.sv
// cell_proc_if: requester, processor and response signals between the arbiter and its environment
interface cell_proc_if #(
  parameter int NUM_REQ = 2,
  parameter int CELL_W = 8,
  parameter int USER_W = 8,
  parameter int OP_W = 4,
  parameter int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ-1:0] req_ready;
  logic [NUM_REQ*CELL_W-1:0] req_cellA;
  logic [NUM_REQ*CELL_W-1:0] req_cellB;
  logic [NUM_REQ*USER_W-1:0] req_user;
  logic [NUM_REQ*OP_W-1:0] req_opcode;
  logic [CELL_W-1:0] proc_cellA;
  logic [CELL_W-1:0] proc_cellB;
  logic [USER_W-1:0] proc_user;
  logic [OP_W-1:0] proc_opcode;
  logic [CELL_W-1:0] proc_result;
  logic rsp_valid;
  logic rsp_ready;
  logic [CELL_W-1:0] rsp_cell;
  logic [ID_W-1:0] rsp_id;
  logic busy;
  modport slave (
    input req_valid, req_cellA, req_cellB, req_user, req_opcode, proc_result, rsp_ready,
    output req_ready, proc_cellA, proc_cellB, proc_user, proc_opcode, rsp_valid, rsp_cell, rsp_id, busy
  );
  modport master (
    output req_valid, req_cellA, req_cellB, req_user, req_opcode, proc_result, rsp_ready,
    input req_ready, proc_cellA, proc_cellB, proc_user, proc_opcode, rsp_valid, rsp_cell, rsp_id, busy
  );
endinterface

// File: rtl/cell_proc_arbiter.sv
// cell_proc_arbiter: round-robin sharing of one CellProcessor with tag tracking and a credit-guarded response FIFO
module cell_proc_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int CELL_W = 8,
  parameter int USER_W = 8,
  parameter int OP_W = 4,
  parameter int PROC_LATENCY = 1,
  parameter int RSP_DEPTH = 4,
  parameter logic [OP_W-1:0] IDLE_OP = '0
) (
  input logic clk,
  input logic rst,
  cell_proc_if.slave bus
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int AW = $clog2(RSP_DEPTH);
  localparam int CW = $clog2(RSP_DEPTH + 1);

  logic [ID_W-1:0] rr_ptr, grant_id, idx;
  logic grant_any, can_issue, xfer, push, pop;
  logic [CW-1:0] outstanding, cnt;
  logic [AW-1:0] wp, rp;
  logic [CELL_W-1:0] sel_a, sel_b;
  logic [USER_W-1:0] sel_u;
  logic [OP_W-1:0] sel_op;
  logic [PROC_LATENCY:0] tag_v;
  logic [ID_W-1:0] tag_id [PROC_LATENCY+1];
  logic [CELL_W-1:0] mem_cell [RSP_DEPTH];
  logic [ID_W-1:0] mem_id [RSP_DEPTH];

  // issue is gated only by the registered credit count, so rsp_ready never reaches req_ready
  assign can_issue = outstanding < CW'(RSP_DEPTH);
  assign xfer = rst & grant_any;
  assign pop = bus.rsp_valid & bus.rsp_ready;
  assign push = tag_v[PROC_LATENCY];

  always_comb begin
    grant_any = 1'b0;
    grant_id = '0;
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (can_issue && bus.req_valid[idx]) begin
        grant_any = 1'b1;
        grant_id = idx;
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    sel_u = '0;
    sel_op = IDLE_OP;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        sel_a = bus.req_cellA[i*CELL_W +: CELL_W];
        sel_b = bus.req_cellB[i*CELL_W +: CELL_W];
        sel_u = bus.req_user[i*USER_W +: USER_W];
        sel_op = bus.req_opcode[i*OP_W +: OP_W];
      end
    end
  end

  assign bus.req_ready = xfer ? NUM_REQ'(1) << grant_id : '0;
  assign bus.rsp_valid = rst & (cnt != '0);
  assign bus.busy = rst & (outstanding != '0);
  assign bus.rsp_cell = mem_cell[rp];
  assign bus.rsp_id = mem_id[rp];

  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr <= '0;
      outstanding <= '0;
      bus.proc_cellA <= '0;
      bus.proc_cellB <= '0;
      bus.proc_user <= '0;
      bus.proc_opcode <= IDLE_OP;
    end else begin
      outstanding <= outstanding + CW'(xfer) - CW'(pop);
      bus.proc_opcode <= xfer ? sel_op : IDLE_OP;
      if (xfer) begin
        rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
        bus.proc_cellA <= sel_a;
        bus.proc_cellB <= sel_b;
        bus.proc_user <= sel_u;
      end
    end
  end

  // stage k of the tag pipe lines up with the processor's k-th internal cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      tag_v <= '0;
    end else begin
      tag_v[0] <= xfer;
      for (int i = 1; i <= PROC_LATENCY; i++) tag_v[i] <= tag_v[i-1];
    end
    tag_id[0] <= grant_id;
    for (int i = 1; i <= PROC_LATENCY; i++) tag_id[i] <= tag_id[i-1];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_cell[wp] <= bus.proc_result;
      mem_id[wp] <= tag_id[PROC_LATENCY];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) assert (!(push && cnt == CW'(RSP_DEPTH))) else $error("response fifo overflow");
  end
endmodule

// File: tb/tb_cell_proc_arbiter.sv
// tb_cell_proc_arbiter: directed checks of grant order, latency, credit stall, wrap and reset flush
module tb_cell_proc_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_chk = 0;
  int n_pass = 0;

  cell_proc_if #(.NUM_REQ(2), .CELL_W(8), .USER_W(8), .OP_W(4)) bus ();

  cell_proc_arbiter #(
    .NUM_REQ(2), .CELL_W(8), .USER_W(8), .OP_W(4),
    .PROC_LATENCY(1), .RSP_DEPTH(4), .IDLE_OP(4'd0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] proc_f(input logic [7:0] a, b, u, input logic [3:0] op);
    return (op == 4'd1) ? a + b : (op == 4'd2) ? a - b : (op == 4'd3) ? a ^ b ^ u : 8'h00;
  endfunction

  always_ff @(posedge clk) bus.proc_result <= proc_f(bus.proc_cellA, bus.proc_cellB, bus.proc_user, bus.proc_opcode);

  task automatic set_req(input int i, input logic [7:0] a, b, u, input logic [3:0] op);
    bus.req_cellA[i*8 +: 8] = a;
    bus.req_cellB[i*8 +: 8] = b;
    bus.req_user[i*8 +: 8] = u;
    bus.req_opcode[i*4 +: 4] = op;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.rsp_ready = 1'b0;
    bus.req_valid = 2'b11;
    set_req(0, 8'h00, 8'h00, 8'h00, 4'd0);
    set_req(1, 8'h00, 8'h00, 8'h00, 4'd0);
    repeat (3) @(negedge clk);
    #1;
    n_chk++; if (bus.req_ready !== 2'b00) $display("FAIL reset_ready: got %b want 00", bus.req_ready); else n_pass++;
    n_chk++; if (bus.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); else n_pass++;
    n_chk++; if (bus.proc_opcode !== 4'd0) $display("FAIL reset_opcode: got %h want 0", bus.proc_opcode); else n_pass++;
    n_chk++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid = 2'b00;
  endtask

  task automatic test_single();
    @(negedge clk);
    set_req(0, 8'h10, 8'h20, 8'h00, 4'd1);
    bus.req_valid = 2'b01;
    #1;
    n_chk++; if (bus.req_ready !== 2'b01) $display("FAIL single_ready: got %b want 01", bus.req_ready); else n_pass++;
    @(negedge clk);
    bus.req_valid = 2'b00;
    #1;
    n_chk++; if ({bus.proc_cellA, bus.proc_cellB, bus.proc_opcode} !== {8'h10, 8'h20, 4'd1})
      $display("FAIL single_issue: got %h %h %h want 10 20 1", bus.proc_cellA, bus.proc_cellB, bus.proc_opcode); else n_pass++;
    n_chk++; if ({bus.busy, bus.rsp_valid} !== 2'b10) $display("FAIL single_busy: got busy=%b rsp_valid=%b want 1 0", bus.busy, bus.rsp_valid); else n_pass++;
    @(negedge clk);
    #1;
    n_chk++; if ({bus.proc_opcode, bus.rsp_valid} !== {4'd0, 1'b0})
      $display("FAIL single_idle: got op=%h rsp_valid=%b want 0 0", bus.proc_opcode, bus.rsp_valid); else n_pass++;
    @(negedge clk);
    #1;
    n_chk++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_cell} !== {1'b1, 1'b0, 8'h30})
      $display("FAIL single_rsp: got v=%b id=%h cell=%h want 1 0 30", bus.rsp_valid, bus.rsp_id, bus.rsp_cell); else n_pass++;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    n_chk++; if ({bus.rsp_valid, bus.busy} !== 2'b00) $display("FAIL single_drain: got v=%b busy=%b want 0 0", bus.rsp_valid, bus.busy); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int eg [6] = '{1, 0, 1, 0, 1, 0};
    set_req(0, 8'h01, 8'h02, 8'h00, 4'd1);
    set_req(1, 8'h05, 8'h03, 8'h00, 4'd2);
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      bus.req_valid = (i < 6) ? 2'b11 : 2'b00;
      #1;
      if (i < 6) begin
        n_chk++; if (bus.req_ready !== 2'(1 << eg[i])) $display("FAIL b2b_grant[%0d]: got %b want %b", i, bus.req_ready, 2'(1 << eg[i])); else n_pass++;
      end
      if (i >= 3) begin
        n_chk++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_cell} !== {1'b1, 1'(eg[i-3]), (eg[i-3] == 1) ? 8'h02 : 8'h03})
          $display("FAIL b2b_rsp[%0d]: got v=%b id=%h cell=%h want id=%0d", i - 3, bus.rsp_valid, bus.rsp_id, bus.rsp_cell, eg[i-3]); else n_pass++;
      end
    end
    @(negedge clk);
    #1;
    n_chk++; if ({bus.rsp_valid, bus.busy} !== 2'b00) $display("FAIL b2b_drain: got v=%b busy=%b want 0 0", bus.rsp_valid, bus.busy); else n_pass++;
  endtask

  task automatic test_credit();
    int nx = 0;
    int pops = 0;
    set_req(0, 8'h11, 8'h01, 8'h00, 4'd1);
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.req_valid = 2'b01;
      #1;
      if (bus.req_ready[0]) nx++;
    end
    n_chk++; if (nx !== 4) $display("FAIL credit_transfers: got %0d want 4", nx); else n_pass++;
    n_chk++; if ({bus.req_ready, bus.busy, bus.rsp_valid, bus.rsp_cell} !== {2'b00, 1'b1, 1'b1, 8'h12})
      $display("FAIL credit_full: got ready=%b busy=%b v=%b cell=%h want 00 1 1 12", bus.req_ready, bus.busy, bus.rsp_valid, bus.rsp_cell); else n_pass++;
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    #1;
    n_chk++; if (bus.req_ready !== 2'b00) $display("FAIL credit_pop_cycle: got %b want 00", bus.req_ready); else n_pass++;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    #1;
    n_chk++; if (bus.req_ready !== 2'b01) $display("FAIL credit_resume: got %b want 01", bus.req_ready); else n_pass++;
    @(negedge clk);
    #1;
    n_chk++; if (bus.req_ready !== 2'b00) $display("FAIL credit_refull: got %b want 00", bus.req_ready); else n_pass++;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.req_valid = 2'b00;
      bus.rsp_ready = 1'b1;
      #1;
      if (!bus.busy) break;
      if (bus.rsp_valid) pops++;
    end
    n_chk++; if ({pops == 4, bus.busy} !== 2'b10) $display("FAIL credit_drain: got pops=%0d busy=%b want 4 0", pops, bus.busy); else n_pass++;
  endtask

  task automatic test_wrap();
    logic [1:0] vp [3] = '{2'b01, 2'b10, 2'b01};
    set_req(0, 8'h03, 8'h04, 8'h00, 4'd3);
    set_req(1, 8'h0f, 8'h01, 8'h00, 4'd2);
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.req_valid = (i < 3) ? vp[i] : 2'b00;
      #1;
      if (i < 3) begin
        n_chk++; if (bus.req_ready !== vp[i]) $display("FAIL wrap_grant[%0d]: got %b want %b", i, bus.req_ready, vp[i]); else n_pass++;
      end else begin
        n_chk++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_cell} !== {1'b1, vp[i-3][1], vp[i-3][1] ? 8'h0e : 8'h07})
          $display("FAIL wrap_rsp[%0d]: got v=%b id=%h cell=%h", i - 3, bus.rsp_valid, bus.rsp_id, bus.rsp_cell); else n_pass++;
      end
    end
  endtask

  task automatic test_flush();
    int hits = 0;
    set_req(0, 8'h10, 8'h20, 8'h00, 4'd1);
    set_req(1, 8'h22, 8'h11, 8'h00, 4'd2);
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.req_valid = 2'b11;
      #1;
      n_chk++; if (bus.req_ready !== ((i == 1) ? 2'b01 : 2'b10)) $display("FAIL flush_grant[%0d]: got %b", i, bus.req_ready); else n_pass++;
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_chk++; if ({bus.req_ready, bus.rsp_valid, bus.busy} !== 4'b0000)
      $display("FAIL flush_in_reset: got ready=%b v=%b busy=%b want 00 0 0", bus.req_ready, bus.rsp_valid, bus.busy); else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid = 2'b00;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (bus.rsp_valid || bus.busy) hits++;
      @(negedge clk);
      #1;
    end
    n_chk++; if (hits !== 0) $display("FAIL flush_stale: got %0d stale cycles want 0", hits); else n_pass++;
    bus.req_valid = 2'b11;
    #1;
    n_chk++; if (bus.req_ready !== 2'b01) $display("FAIL flush_rr: got %b want 01", bus.req_ready); else n_pass++;
    @(negedge clk);
    bus.req_valid = 2'b00;
    repeat (2) @(negedge clk);
    #1;
    n_chk++; if ({bus.rsp_valid, bus.rsp_id, bus.rsp_cell} !== {1'b1, 1'b0, 8'h30})
      $display("FAIL flush_rsp: got v=%b id=%h cell=%h want 1 0 30", bus.rsp_valid, bus.rsp_id, bus.rsp_cell); else n_pass++;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_credit();
    test_wrap();
    test_flush();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
